// File: rtl/fifo_slice_reader.sv
// fifo_slice_reader
//
// Pop-side consumer for the overflow FIFO. Pops one DW-wide entry into a
// private holding register, then streams it as DW/OW narrow beats on a
// valid/ready output. The FIFO is free to overwrite its head as soon as the
// pop is taken, because the beats are always served from the holding copy.
//
// Build option:
//   FIFO_SLICE_READER_MSB_FIRST_EN  defined   -> beats issued MSB-first
//                                   undefined -> beats issued LSB-first
//   Handshake and timing are identical in both builds.
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   flush       synchronous abort of the entry in progress (highest priority)
//   fifo_data   FIFO head entry [DW]
//   fifo_valid  FIFO non-empty
//   fifo_pop    pop request to the FIFO (combinational)
//   out_data    current beat [OW]
//   out_valid   beat valid
//   out_last    final beat of the current entry
//   out_ready   sink accepts the beat
//   busy        holding register occupied
//
// State | meaning
// ------+------------------------------------------------
// EMPTY | no entry held, pop as soon as the FIFO has one
// FULL  | entry held in hold_q, beat idx_q on the output

module fifo_slice_reader #(
    parameter int DW = 64,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] fifo_data,
    input  logic          fifo_valid,
    output logic          fifo_pop,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy
);

    localparam int RATIO = DW / OW;
    localparam int IW    = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    generate
        if (RATIO < 2 || (DW % OW) != 0) begin : g_bad_params
            $fatal(1, "fifo_slice_reader: DW must be a multiple of OW with DW/OW >= 2");
        end
    endgenerate

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [IW-1:0] slice_sel;
    logic          acc;
    logic          at_last;

    assign busy      = (state_q == ST_FULL);
    assign out_valid = busy & ~flush;
    assign at_last   = (idx_q == LAST_IDX);
    assign out_last  = out_valid & at_last;
    assign acc       = out_valid & out_ready;

    // A pop on the last accepted beat reloads in the same cycle, so
    // consecutive entries stream without a bubble.
    assign fifo_pop  = fifo_valid & ~flush & ((state_q == ST_EMPTY) | (acc & at_last));

`ifdef FIFO_SLICE_READER_MSB_FIRST_EN
    assign slice_sel = LAST_IDX - idx_q;
`else
    assign slice_sel = idx_q;
`endif

    assign out_data = hold_q[int'(slice_sel) * OW +: OW];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (flush) begin
            // hold_q is deliberately left alone; only the sequencing resets.
            state_d = ST_EMPTY;
            idx_d   = '0;
        end else if (fifo_pop) begin
            hold_d  = fifo_data;
            idx_d   = '0;
            state_d = ST_FULL;
        end else if (acc) begin
            if (at_last) begin
                state_d = ST_EMPTY;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

`ifndef SYNTHESIS
    a_pop_needs_valid : assert property (@(posedge clk) disable iff (rst)
        fifo_pop |-> fifo_valid);
    a_stall_stable : assert property (@(posedge clk) disable iff (rst)
        out_valid & ~out_ready & ~flush |=> out_valid & $stable(out_data));
    a_last_needs_valid : assert property (@(posedge clk) disable iff (rst)
        out_last |-> out_valid);
`endif

endmodule

// File: tb/tb_fifo_slice_reader.sv
module tb_fifo_slice_reader;

    localparam int DW    = 64;
    localparam int OW    = 16;
    localparam int RATIO = DW / OW;

    localparam logic [DW-1:0] E1  = 64'h4444_3333_2222_1111;
    localparam logic [DW-1:0] E2  = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [DW-1:0] JNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [DW-1:0] fifo_data;
    logic          fifo_valid;
    logic          fifo_pop;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // {last, data} per expected beat
    logic [OW:0] sb[$];

    fifo_slice_reader #(.DW(DW), .OW(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_pop   (fifo_pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input logic [DW-1:0] e);
        logic [OW-1:0] s;
        for (int k = 0; k < RATIO; k++) begin
`ifdef FIFO_SLICE_READER_MSB_FIRST_EN
            s = e[(RATIO-1-k)*OW +: OW];
`else
            s = e[k*OW +: OW];
`endif
            sb.push_back({(k == RATIO-1), s});
        end
    endtask

    // Sample on the falling edge; any handshake is scored against the queue.
    task automatic sample();
        logic [OW:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("sb_has_beat", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_data", 64'(out_data), 64'(e[OW-1:0]));
                chk("beat_last", 64'(out_last), 64'(e[OW]));
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        fifo_data  = '0;
        fifo_valid = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        sample();
        chk("rst_flags", 64'({out_valid, fifo_pop, busy, out_last}), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        next();
        rst = 1'b0;

        // idle with empty FIFO
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("idle_flags", 64'({out_valid, fifo_pop, busy, out_last}), 64'd0);
            next();
        end

        // single entry, sink always ready; FIFO head overwritten after pop
        out_ready  = 1'b1;
        fifo_data  = E1;
        fifo_valid = 1'b1;
        push_entry(E1);
        sample();
        chk("s2_pop", 64'(fifo_pop), 64'd1);
        chk("s2_busy0", 64'(busy), 64'd0);
        chk("s2_valid0", 64'(out_valid), 64'd0);
        next();
        fifo_valid = 1'b0;
        fifo_data  = JNK;
        for (int i = 1; i <= 4; i++) begin
            sample();
            chk("s2_valid", 64'(out_valid), 64'd1);
            chk("s2_last", 64'(out_last), 64'(i == 4));
            chk("s2_nopop", 64'(fifo_pop), 64'd0);
            next();
        end
        sample();
        chk("s2_done", 64'({out_valid, busy}), 64'd0);
        next();

        // back-to-back entries, no bubble
        fifo_data  = E1;
        fifo_valid = 1'b1;
        push_entry(E1);
        sample();
        chk("s3_pop0", 64'(fifo_pop), 64'd1);
        next();
        fifo_data = E2;
        push_entry(E2);
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) begin
                fifo_valid = 1'b0;
                fifo_data  = JNK;
            end
            sample();
            chk("s3_valid", 64'(out_valid), 64'd1);
            chk("s3_pop", 64'(fifo_pop), 64'(i == 4));
            chk("s3_last", 64'(out_last), 64'(i == 4 || i == 8));
            next();
        end
        sample();
        chk("s3_done", 64'({out_valid, busy}), 64'd0);
        next();

        // stall on the second beat, then stall on the last beat with FIFO ready
        fifo_data  = E1;
        fifo_valid = 1'b1;
        push_entry(E1);
        sample();
        chk("s4_pop0", 64'(fifo_pop), 64'd1);
        next();
        fifo_valid = 1'b0;
        fifo_data  = JNK;
        sample();
        next();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("s4_stall_data", 64'(out_data), 64'h2222);
            chk("s4_stall_valid", 64'(out_valid), 64'd1);
            chk("s4_stall_nopop", 64'(fifo_pop), 64'd0);
            next();
        end
        out_ready = 1'b1;
        sample();
        next();
        sample();
        next();
        out_ready  = 1'b0;
        fifo_valid = 1'b1;
        fifo_data  = E2;
        push_entry(E2);
        sample();
        chk("s4_laststall_nopop", 64'(fifo_pop), 64'd0);
        chk("s4_laststall_last", 64'(out_last), 64'd1);
        chk("s4_laststall_data", 64'(out_data), 64'h4444);
        next();
        out_ready = 1'b1;
        sample();
        chk("s4_reload_pop", 64'(fifo_pop), 64'd1);
        next();
        fifo_valid = 1'b0;
        fifo_data  = JNK;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("s4_e2_valid", 64'(out_valid), 64'd1);
            next();
        end
        sample();
        chk("s4_done", 64'({out_valid, busy}), 64'd0);
        next();

        // flush while the second beat is presented
        fifo_data  = E1;
        fifo_valid = 1'b1;
        push_entry(E1);
        sample();
        chk("s5_pop0", 64'(fifo_pop), 64'd1);
        next();
        fifo_valid = 1'b0;
        fifo_data  = JNK;
        sample();
        next();
        flush      = 1'b1;
        fifo_valid = 1'b1;
        fifo_data  = E2;
        sb.delete();
        push_entry(E2);
        sample();
        chk("s5_flush_valid", 64'(out_valid), 64'd0);
        chk("s5_flush_pop", 64'(fifo_pop), 64'd0);
        chk("s5_flush_last", 64'(out_last), 64'd0);
        next();
        flush = 1'b0;
        sample();
        chk("s5_after_pop", 64'(fifo_pop), 64'd1);
        chk("s5_after_valid", 64'(out_valid), 64'd0);
        chk("s5_after_busy", 64'(busy), 64'd0);
        next();
        fifo_valid = 1'b0;
        fifo_data  = JNK;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("s5_valid", 64'(out_valid), 64'd1);
            chk("s5_last", 64'(out_last), 64'(i == 3));
            next();
        end
        sample();
        chk("s5_done", 64'({out_valid, busy}), 64'd0);
        next();

        // asynchronous reset mid-word
        fifo_data  = E2;
        fifo_valid = 1'b1;
        push_entry(E2);
        sample();
        next();
        fifo_valid = 1'b0;
        fifo_data  = JNK;
        sample();
        next();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("s6_rst_flags", 64'({out_valid, fifo_pop, busy, out_last}), 64'd0);
        chk("s6_rst_data", 64'(out_data), 64'd0);
        sb.delete();
        next();
        rst = 1'b0;
        sample();
        chk("s6_idle", 64'({out_valid, fifo_pop, busy, out_last}), 64'd0);
        next();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
